// File: rtl/core_instr_driver.sv
// rtl/core_instr_driver.sv - credit-throttled CORE instruction issuer with result FIFO
module core_instr_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int PROG_DEPTH = 16,
  parameter int RES_DEPTH  = 8
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic                          i_prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] i_prog_addr,
  input  logic [31:0]                   i_prog_data,
  input  logic                          i_start,
  input  logic [$clog2(PROG_DEPTH):0]   i_len,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [31:0]                   o_instr,
  output logic                          o_valid,
  input  logic                          i_ready,
  input  logic [DATA_WIDTH-1:0]         i_data1,
  input  logic                          i_valid1,
  output logic                          o_ready1,
  output logic [DATA_WIDTH-1:0]         o_res_data,
  output logic                          o_res_valid,
  input  logic                          i_res_ready,
  output logic [$clog2(PROG_DEPTH):0]   o_issued,
  output logic [$clog2(PROG_DEPTH):0]   o_received
);

  localparam int AW  = $clog2(PROG_DEPTH);
  localparam int CW  = AW + 1;
  localparam int SW  = CW + 1;
  localparam int FW  = $clog2(RES_DEPTH);
  localparam int FCW = FW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  state, state_n;
  logic [31:0]             prog_ram [PROG_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_ram [RES_DEPTH];
  logic [AW-1:0]           rd_ptr, rd_ptr_n;
  logic [CW-1:0]           len_q, len_n, issued_n, received_n;
  logic [FW-1:0]           f_wr, f_rd, f_wr_n, f_rd_n;
  logic [FCW-1:0]          f_cnt, f_cnt_n;
  logic [SW-1:0]           inflight_n;
  logic [31:0]             ram_rd, instr_n;
  logic [DATA_WIDTH-1:0]   res_data_n;
  logic                    xfer, push, pop, counting, prog_wr, credit_n;
  logic                    valid_n, busy_n, done_n, ready_n, res_valid_n;

  always_comb begin
    xfer       = o_valid && i_ready;
    push       = i_valid1 && o_ready1;
    pop        = o_res_valid && i_res_ready;
    counting   = (state == S_ISSUE) || (state == S_DRAIN);
    prog_wr    = i_prog_we && !o_busy;
    state_n    = state;
    rd_ptr_n   = rd_ptr;
    len_n      = len_q;
    issued_n   = o_issued;
    received_n = o_received;
    if (counting) begin
      issued_n   = o_issued + CW'(xfer);
      received_n = o_received + CW'(push);
      rd_ptr_n   = rd_ptr + AW'(xfer);
    end
    case (state)
      S_IDLE: if (i_start) begin
        issued_n   = '0;
        received_n = '0;
        rd_ptr_n   = '0;
        len_n      = i_len;
        state_n    = (i_len != '0) ? S_ISSUE : S_DONE;
      end
      S_ISSUE: if (issued_n == len_q) state_n = (received_n == len_q) ? S_DONE : S_DRAIN;
      S_DRAIN: if (received_n == len_q) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase

    f_cnt_n = f_cnt + FCW'(push) - FCW'(pop);
    f_wr_n  = f_wr + FW'(push);
    f_rd_n  = f_rd + FW'(pop);

    // Results already parked in the FIFO still hold a credit until popped
    inflight_n = {1'b0, issued_n - received_n} + SW'(f_cnt_n);
    credit_n   = inflight_n < SW'(RES_DEPTH);
    valid_n    = (state_n == S_ISSUE) && ((o_valid && !xfer) || credit_n);

    // Forward a same-cycle program write so a run started alongside it sees the new word
    ram_rd = prog_ram[rd_ptr_n];
    if (prog_wr && (i_prog_addr == rd_ptr_n)) ram_rd = i_prog_data;
    instr_n = o_instr;
    if (valid_n && !(o_valid && !xfer)) instr_n = ram_rd;

    busy_n      = (state_n == S_ISSUE) || (state_n == S_DRAIN);
    done_n      = (state_n == S_DONE);
    ready_n     = (f_cnt_n != FCW'(RES_DEPTH));
    res_valid_n = (f_cnt_n != '0);
    res_data_n  = o_res_data;
    if (res_valid_n) res_data_n = (push && (f_wr == f_rd_n)) ? i_data1 : fifo_ram[f_rd_n];
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state       <= S_IDLE;
      o_valid     <= 1'b0;
      o_instr     <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_ready1    <= 1'b1;
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
      o_issued    <= '0;
      o_received  <= '0;
      rd_ptr      <= '0;
      len_q       <= '0;
      f_wr        <= '0;
      f_rd        <= '0;
      f_cnt       <= '0;
    end else begin
      state       <= state_n;
      o_valid     <= valid_n;
      o_instr     <= instr_n;
      o_busy      <= busy_n;
      o_done      <= done_n;
      o_ready1    <= ready_n;
      o_res_valid <= res_valid_n;
      o_res_data  <= res_data_n;
      o_issued    <= issued_n;
      o_received  <= received_n;
      rd_ptr      <= rd_ptr_n;
      len_q       <= len_n;
      f_wr        <= f_wr_n;
      f_rd        <= f_rd_n;
      f_cnt       <= f_cnt_n;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (prog_wr) prog_ram[i_prog_addr] <= i_prog_data;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST && push) fifo_ram[f_wr] <= i_data1;
  end

endmodule

// File: tb/tb_core_instr_driver.sv
// tb/tb_core_instr_driver.sv - directed vector bench for core_instr_driver
module tb_core_instr_driver;

  logic        clk = 1'b0;
  logic        i_RST = 1'b1;
  logic        i_prog_we = 1'b0;
  logic [3:0]  i_prog_addr = '0;
  logic [31:0] i_prog_data = '0;
  logic        i_start = 1'b0;
  logic [4:0]  i_len = '0;
  logic        o_busy, o_done, o_valid, o_ready1, o_res_valid;
  logic [31:0] o_instr;
  logic        i_ready = 1'b0;
  logic [7:0]  i_data1 = '0;
  logic        i_valid1 = 1'b0;
  logic [7:0]  o_res_data;
  logic        i_res_ready = 1'b0;
  logic [4:0]  o_issued, o_received;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_instr_driver dut (
    .i_CLK(clk), .i_RST(i_RST),
    .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr), .i_prog_data(i_prog_data),
    .i_start(i_start), .i_len(i_len), .o_busy(o_busy), .o_done(o_done),
    .o_instr(o_instr), .o_valid(o_valid), .i_ready(i_ready),
    .i_data1(i_data1), .i_valid1(i_valid1), .o_ready1(o_ready1),
    .o_res_data(o_res_data), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_issued(o_issued), .o_received(o_received)
  );

  typedef struct {
    logic        start;
    logic [4:0]  len;
    logic        rdy;
    logic        v1;
    logic [7:0]  d1;
    logic        rr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_busy;
    logic        e_done;
    logic [4:0]  e_iss;
    logic [4:0]  e_rec;
    logic        e_resv;
    logic [7:0]  e_rd;
  } vec_t;

  localparam int NROW = 21;
  vec_t tbl [NROW];

  function automatic vec_t mk(input int st, input int ln, input int rdy, input int v1,
                              input int d1, input int rr, input int ev, input logic [31:0] ei,
                              input int eb, input int ed, input int eis, input int erc,
                              input int erv, input int erd);
    vec_t v;
    v.start = st[0];   v.len = ln[4:0];    v.rdy = rdy[0];  v.v1 = v1[0];
    v.d1 = d1[7:0];    v.rr = rr[0];       v.e_valid = ev[0]; v.e_instr = ei;
    v.e_busy = eb[0];  v.e_done = ed[0];   v.e_iss = eis[4:0]; v.e_rec = erc[4:0];
    v.e_resv = erv[0]; v.e_rd = erd[7:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [3:0] addr, input logic [31:0] data);
    i_prog_we = 1'b1; i_prog_addr = addr; i_prog_data = data;
    tick();
    i_prog_we = 1'b0;
  endtask

  task automatic start_run(input logic [4:0] len);
    i_start = 1'b1; i_len = len;
    tick();
    i_start = 1'b0;
  endtask

  // CORE responder: every accepted instruction returns one result on the following cycle
  task automatic run_loop(input int ncyc, input logic [31:0] exp_base,
                          output int nx, output int ndone);
    logic       pend;
    logic [7:0] pdat;
    nx = 0; ndone = 0; pend = 1'b0; pdat = '0;
    for (int c = 0; c < ncyc; c++) begin
      i_valid1 = pend;
      i_data1  = pdat;
      if (o_valid && i_ready) begin
        chk($sformatf("xfer%0d_instr", nx), o_instr, exp_base + 32'(nx));
        pend = 1'b1;
        pdat = 8'hA0 + 8'(nx);
        nx++;
      end else begin
        pend = 1'b0;
      end
      tick();
      if (o_done) ndone++;
    end
    i_valid1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nx, nd;
    logic [7:0] q [$];

    // start, len, rdy, v1, d1, rr | valid, instr, busy, done, issued, received, res_valid, res_data
    tbl[0]  = mk(1, 3, 1, 0, 'h00, 1, 1, 32'h0C220000, 1, 0, 0, 0, 0, 'h00);
    tbl[1]  = mk(0, 3, 1, 0, 'h00, 1, 1, 32'h50620000, 1, 0, 1, 0, 0, 'h00);
    tbl[2]  = mk(0, 3, 1, 1, 'h11, 1, 1, 32'h8A220000, 1, 0, 2, 1, 1, 'h11);
    tbl[3]  = mk(0, 3, 1, 1, 'h22, 1, 0, 32'h8A220000, 1, 0, 3, 2, 1, 'h22);
    tbl[4]  = mk(0, 3, 1, 1, 'h33, 1, 0, 32'h8A220000, 0, 1, 3, 3, 1, 'h33);
    tbl[5]  = mk(0, 3, 1, 0, 'h00, 1, 0, 32'h8A220000, 0, 0, 3, 3, 0, 'h33);
    tbl[6]  = mk(1, 3, 0, 0, 'h00, 0, 1, 32'h0C220000, 1, 0, 0, 0, 0, 'h33);
    tbl[7]  = mk(0, 3, 1, 0, 'h00, 0, 1, 32'h50620000, 1, 0, 1, 0, 0, 'h33);
    tbl[8]  = mk(0, 3, 0, 1, 'h44, 0, 1, 32'h50620000, 1, 0, 1, 1, 1, 'h44);
    tbl[9]  = mk(0, 3, 0, 0, 'h00, 0, 1, 32'h50620000, 1, 0, 1, 1, 1, 'h44);
    tbl[10] = mk(0, 3, 0, 0, 'h00, 0, 1, 32'h50620000, 1, 0, 1, 1, 1, 'h44);
    tbl[11] = mk(0, 3, 0, 0, 'h00, 0, 1, 32'h50620000, 1, 0, 1, 1, 1, 'h44);
    tbl[12] = mk(0, 3, 1, 0, 'h00, 0, 1, 32'h8A220000, 1, 0, 2, 1, 1, 'h44);
    tbl[13] = mk(0, 3, 1, 1, 'h55, 0, 0, 32'h8A220000, 1, 0, 3, 2, 1, 'h44);
    tbl[14] = mk(0, 3, 1, 1, 'h66, 0, 0, 32'h8A220000, 0, 1, 3, 3, 1, 'h44);
    tbl[15] = mk(0, 3, 0, 0, 'h00, 0, 0, 32'h8A220000, 0, 0, 3, 3, 1, 'h44);
    tbl[16] = mk(0, 3, 0, 0, 'h00, 1, 0, 32'h8A220000, 0, 0, 3, 3, 1, 'h55);
    tbl[17] = mk(0, 3, 0, 0, 'h00, 1, 0, 32'h8A220000, 0, 0, 3, 3, 1, 'h66);
    tbl[18] = mk(0, 3, 0, 0, 'h00, 1, 0, 32'h8A220000, 0, 0, 3, 3, 0, 'h66);
    tbl[19] = mk(1, 0, 0, 0, 'h00, 0, 0, 32'h8A220000, 0, 1, 0, 0, 0, 'h66);
    tbl[20] = mk(0, 0, 0, 0, 'h00, 0, 0, 32'h8A220000, 0, 0, 0, 0, 0, 'h66);

    tick(); tick();
    i_RST = 1'b0;
    chk("rst_valid", o_valid, 0);
    chk("rst_instr", o_instr, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ready1", o_ready1, 1);
    chk("rst_res_valid", o_res_valid, 0);
    chk("rst_res_data", o_res_data, 0);
    chk("rst_issued", o_issued, 0);
    chk("rst_received", o_received, 0);

    prog(4'd0, 32'h0C220000);
    prog(4'd1, 32'h50620000);
    prog(4'd2, 32'h8A220000);

    for (int r = 0; r < NROW; r++) begin
      i_start = tbl[r].start; i_len = tbl[r].len; i_ready = tbl[r].rdy;
      i_valid1 = tbl[r].v1; i_data1 = tbl[r].d1; i_res_ready = tbl[r].rr;
      tick();
      chk($sformatf("r%0d_valid", r), o_valid, tbl[r].e_valid);
      chk($sformatf("r%0d_instr", r), o_instr, tbl[r].e_instr);
      chk($sformatf("r%0d_busy", r), o_busy, tbl[r].e_busy);
      chk($sformatf("r%0d_done", r), o_done, tbl[r].e_done);
      chk($sformatf("r%0d_issued", r), o_issued, tbl[r].e_iss);
      chk($sformatf("r%0d_received", r), o_received, tbl[r].e_rec);
      chk($sformatf("r%0d_res_valid", r), o_res_valid, tbl[r].e_resv);
      chk($sformatf("r%0d_res_data", r), o_res_data, tbl[r].e_rd);
    end
    i_start = 1'b0; i_valid1 = 1'b0; i_res_ready = 1'b0;

    // Credit exhaustion with results left in the FIFO
    for (int a = 0; a < 16; a++) prog(4'(a), 32'h10000000 + 32'(a));
    i_ready = 1'b1;
    start_run(5'd16);
    run_loop(20, 32'h10000000, nx, nd);
    chk("credit_xfers", nx, 8);
    chk("credit_valid_low", o_valid, 0);
    chk("credit_ready1_full", o_ready1, 0);
    chk("credit_issued", o_issued, 8);
    chk("credit_received", o_received, 8);
    chk("credit_no_done", nd, 0);
    chk("credit_head", o_res_data, 8'hA0);
    i_res_ready = 1'b1; tick(); i_res_ready = 1'b0;
    chk("credit_return_valid", o_valid, 1);
    chk("credit_pop_head", o_res_data, 8'hA1);
    run_loop(10, 32'h10000008, nx, nd);
    chk("credit_one_more", nx, 1);
    chk("credit_issued9", o_issued, 9);
    chk("credit_received9", o_received, 9);

    // Reset while an instruction is pending
    i_ready = 1'b0;
    i_res_ready = 1'b1; tick(); i_res_ready = 1'b0;
    chk("pre_rst_valid", o_valid, 1);
    i_RST = 1'b1; tick(); i_RST = 1'b0;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_issued", o_issued, 0);
    chk("mid_rst_received", o_received, 0);
    chk("mid_rst_res_valid", o_res_valid, 0);
    chk("mid_rst_ready1", o_ready1, 1);
    i_ready = 1'b1; i_res_ready = 1'b1;
    start_run(5'd2);
    run_loop(10, 32'h10000000, nx, nd);
    chk("rerun_xfers", nx, 2);
    chk("rerun_done", nd, 1);
    chk("rerun_busy", o_busy, 0);
    chk("rerun_received", o_received, 2);

    // Start and program writes are ignored while busy
    i_ready = 1'b0;
    start_run(5'd2);
    chk("busy_valid", o_valid, 1);
    chk("busy_instr", o_instr, 32'h10000000);
    i_start = 1'b1; i_len = 5'd5;
    i_prog_we = 1'b1; i_prog_addr = 4'd1; i_prog_data = 32'hDEADBEEF;
    tick();
    i_start = 1'b0; i_prog_we = 1'b0;
    chk("busy_ign_issued", o_issued, 0);
    chk("busy_ign_busy", o_busy, 1);
    i_ready = 1'b1;
    run_loop(12, 32'h10000000, nx, nd);
    chk("busy_ign_xfers", nx, 2);
    chk("busy_ign_done", nd, 1);

    // Program write and start in the same cycle
    i_prog_we = 1'b1; i_prog_addr = 4'd0; i_prog_data = 32'hCAFE0000;
    i_start = 1'b1; i_len = 5'd1;
    tick();
    i_prog_we = 1'b0; i_start = 1'b0;
    chk("wr_start_valid", o_valid, 1);
    chk("wr_start_instr", o_instr, 32'hCAFE0000);
    run_loop(8, 32'hCAFE0000, nx, nd);
    chk("wr_start_xfers", nx, 1);
    chk("wr_start_done", nd, 1);

    // FIFO fill to full, then concurrent push/pop across the pointer wrap
    i_res_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      i_valid1 = 1'b1; i_data1 = 8'hC0 + 8'(c);
      if (o_ready1) q.push_back(i_data1);
      tick();
    end
    chk("fifo_full_ready1", o_ready1, 0);
    chk("fifo_full_count", 32'(q.size()), 8);
    chk("fifo_full_head", o_res_data, 8'hC0);
    for (int c = 0; c < 20; c++) begin
      i_res_ready = 1'b1;
      i_valid1 = (c < 6);
      i_data1 = 8'hD0 + 8'(c);
      if (o_res_valid) begin
        if (q.size() == 0) chk("fifo_extra_entry", 32'(o_res_data), 32'hFFFF);
        else chk($sformatf("fifo_order%0d", c), o_res_data, q.pop_front());
      end
      if (o_ready1 && i_valid1) q.push_back(i_data1);
      tick();
    end
    i_valid1 = 1'b0; i_res_ready = 1'b0;
    chk("fifo_drained_model", 32'(q.size()), 0);
    chk("fifo_drained_valid", o_res_valid, 0);
    chk("fifo_drained_ready1", o_ready1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
